hazard_stall_ctrl: RTL and testbench

//  Pipeline sequencing controller for the 5-stage MIPS core. Drives the enable
//  (en) and active-low synchronous clear (reset_b) inputs of the PC, IF/ID,
//  ID/EX and EX/MEM pipeline registers. Implements load-use stall, taken-branch

---
 rtl/hazard_stall_ctrl.sv | 127 ++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing controller for the 5-stage MIPS core.
// Drives the enables and synchronous clears of the PC, IF/ID, ID/EX and EX/MEM
// registers. It handles the load-use stall, the taken-branch flush and the
// multi-cycle mul/div freeze, and it counts the cycles in which the PC is held.
module hazard_stall_ctrl #(
   parameter int REG_AW     = 5,
   parameter int MDU_CYCLES = 4,   // legal range 2..16
   parameter int CNT_W      = 32
) (
   input  logic              clk,
   input  logic              reset_b,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic              id_uses_rt,
   input  logic              ex_memread,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic              ex_branch_tkn,
   input  logic              ex_mdu_start,
   output logic              pc_en,
   output logic              ifid_en,
   output logic              ifid_flush_b,
   output logic              idex_en,
   output logic              idex_flush_b,
   output logic              exmem_flush_b,
   output logic              mdu_done,
   output logic [CNT_W-1:0]  stall_cycles
);

   typedef enum logic {RUN, MDU_WAIT} state_t;

   // The start cycle is itself the first EX cycle, and the done cycle is the
   // last, so the countdown covers only the cycles in between.
   localparam logic [3:0] MDU_LOAD = 4'(MDU_CYCLES - 2);
   // With a 2-cycle unit the result is ready right after the start cycle.
   localparam bit MDU_FREEZES = (MDU_CYCLES >= 3);

   state_t     st, st_nxt;
   logic [3:0] cnt, cnt_nxt;
   logic       idle;
   logic       load_use;

   // A zero destination is never a real dependency, because $0 is hardwired.
   assign load_use = ex_memread && (ex_rd != '0) &&
                     ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));

   // The done cycle of a mul/div behaves exactly like RUN.
   assign idle = (st == RUN) || (cnt == 4'd0);

   // Next-state and pipeline-control decode; the hazard priority applies only when idle.
   // NOTE: every output of this block gets a default first, so no path leaves
   // a signal unassigned and no latch is inferred.
   always_comb begin
      pc_en         = 1'b1;
      ifid_en       = 1'b1;
      ifid_flush_b  = 1'b1;
      idex_en       = 1'b1;
      idex_flush_b  = 1'b1;
      exmem_flush_b = 1'b1;
      mdu_done      = 1'b0;
      st_nxt        = RUN;
      cnt_nxt       = 4'd0;

      if (!idle) begin
         // Mid mul/div: hold the front end and bubble EX/MEM; nothing else matters.
         pc_en         = 1'b0;
         ifid_en       = 1'b0;
         idex_en       = 1'b0;
         exmem_flush_b = 1'b0;
         st_nxt        = MDU_WAIT;
         cnt_nxt       = cnt - 4'd1;
      end else begin
         mdu_done = (st == MDU_WAIT);
         if (ex_branch_tkn) begin
            // The wrong-path instructions in IF/ID and ID are discarded.
            ifid_flush_b = 1'b0;
            idex_flush_b = 1'b0;
         end else if (ex_mdu_start) begin
            st_nxt  = MDU_WAIT;
            cnt_nxt = MDU_LOAD;
            if (MDU_FREEZES) begin
               pc_en         = 1'b0;
               ifid_en       = 1'b0;
               idex_en       = 1'b0;
               exmem_flush_b = 1'b0;
            end
         end else if (load_use) begin
            // Hold PC and IF/ID for one cycle and send a bubble into EX.
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            idex_flush_b = 1'b0;
         end
      end

      if (!reset_b) begin
         pc_en         = 1'b0;
         ifid_en       = 1'b0;
         ifid_flush_b  = 1'b0;
         idex_en       = 1'b0;
         idex_flush_b  = 1'b0;
         exmem_flush_b = 1'b0;
         mdu_done      = 1'b0;
      end
   end

   // State register for the mul/div sequencer.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         st  <= RUN;
         cnt <= 4'd0;
      end else begin
         st  <= st_nxt;
         cnt <= cnt_nxt;
      end
   end

   // Saturating count of cycles in which the PC was held.
   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         stall_cycles <= '0;
      end else if (!pc_en && (stall_cycles != '1)) begin
         stall_cycles <= stall_cycles + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed testbench for hazard_stall_ctrl.
// u_dut: MDU_CYCLES=4, CNT_W=32. u_m2: MDU_CYCLES=2. u_sat: MDU_CYCLES=16,
// CNT_W=3, held in reset by its own reset until the saturation step.
module tb_hazard_stall_ctrl;

   logic       clk;
   logic       reset_b;
   logic       reset_b_s;
   logic [4:0] id_rs;
   logic [4:0] id_rt;
   logic       id_uses_rt;
   logic       ex_memread;
   logic [4:0] ex_rd;
   logic       ex_branch_tkn;
   logic       ex_mdu_start;

   logic        pc_en, ifid_en, ifid_flush_b, idex_en, idex_flush_b, exmem_flush_b, mdu_done;
   logic [31:0] stall_cycles;
   logic        m2_pc_en, m2_ifid_en, m2_ifid_flush_b, m2_idex_en, m2_idex_flush_b, m2_exmem_flush_b, m2_mdu_done;
   logic [31:0] m2_stall_cycles;
   logic        s_pc_en, s_ifid_en, s_ifid_flush_b, s_idex_en, s_idex_flush_b, s_exmem_flush_b, s_mdu_done;
   logic [2:0]  s_stall_cycles;

   // Packed view: {pc_en, ifid_en, ifid_flush_b, idex_en, idex_flush_b, exmem_flush_b, mdu_done}
   logic [6:0] o_main, o_m2, o_sat;
   assign o_main = {pc_en, ifid_en, ifid_flush_b, idex_en, idex_flush_b, exmem_flush_b, mdu_done};
   assign o_m2   = {m2_pc_en, m2_ifid_en, m2_ifid_flush_b, m2_idex_en, m2_idex_flush_b, m2_exmem_flush_b, m2_mdu_done};
   assign o_sat  = {s_pc_en, s_ifid_en, s_ifid_flush_b, s_idex_en, s_idex_flush_b, s_exmem_flush_b, s_mdu_done};

   localparam logic [6:0] O_ZERO = 7'b0000000;
   localparam logic [6:0] O_NORM = 7'b1111110;
   localparam logic [6:0] O_LU   = 7'b0011010;
   localparam logic [6:0] O_BR   = 7'b1101010;
   localparam logic [6:0] O_FRZ  = 7'b0010100;
   localparam logic [6:0] O_DONE = 7'b1111111;
   localparam logic [6:0] O_DFRZ = 7'b0010101;

   int checks = 0;
   int errors = 0;

   hazard_stall_ctrl #(.REG_AW(5), .MDU_CYCLES(4), .CNT_W(32)) u_dut (
      .clk(clk), .reset_b(reset_b), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
      .ex_memread(ex_memread), .ex_rd(ex_rd), .ex_branch_tkn(ex_branch_tkn),
      .ex_mdu_start(ex_mdu_start), .pc_en(pc_en), .ifid_en(ifid_en),
      .ifid_flush_b(ifid_flush_b), .idex_en(idex_en), .idex_flush_b(idex_flush_b),
      .exmem_flush_b(exmem_flush_b), .mdu_done(mdu_done), .stall_cycles(stall_cycles)
   );

   hazard_stall_ctrl #(.REG_AW(5), .MDU_CYCLES(2), .CNT_W(32)) u_m2 (
      .clk(clk), .reset_b(reset_b), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
      .ex_memread(ex_memread), .ex_rd(ex_rd), .ex_branch_tkn(ex_branch_tkn),
      .ex_mdu_start(ex_mdu_start), .pc_en(m2_pc_en), .ifid_en(m2_ifid_en),
      .ifid_flush_b(m2_ifid_flush_b), .idex_en(m2_idex_en), .idex_flush_b(m2_idex_flush_b),
      .exmem_flush_b(m2_exmem_flush_b), .mdu_done(m2_mdu_done), .stall_cycles(m2_stall_cycles)
   );

   hazard_stall_ctrl #(.REG_AW(5), .MDU_CYCLES(16), .CNT_W(3)) u_sat (
      .clk(clk), .reset_b(reset_b_s), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
      .ex_memread(ex_memread), .ex_rd(ex_rd), .ex_branch_tkn(ex_branch_tkn),
      .ex_mdu_start(ex_mdu_start), .pc_en(s_pc_en), .ifid_en(s_ifid_en),
      .ifid_flush_b(s_ifid_flush_b), .idex_en(s_idex_en), .idex_flush_b(s_idex_flush_b),
      .exmem_flush_b(s_exmem_flush_b), .mdu_done(s_mdu_done), .stall_cycles(s_stall_cycles)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      id_rs         = 5'd0;
      id_rt         = 5'd0;
      id_uses_rt    = 1'b0;
      ex_memread    = 1'b0;
      ex_rd         = 5'd0;
      ex_branch_tkn = 1'b0;
      ex_mdu_start  = 1'b0;
   endtask

   initial begin
      reset_b   = 1'b0;
      reset_b_s = 1'b0;
      clear_inputs();
      #2;
      check("reset_outs", 32'(o_main), 32'(O_ZERO));
      check("reset_stall", stall_cycles, 32'd0);
      tick();
      check("reset_hold_outs", 32'(o_main), 32'(O_ZERO));

      // 1. Reset release, no hazards for 10 cycles.
      reset_b = 1'b1;
      #1;
      for (int i = 0; i < 10; i++) begin
         check("idle_outs", 32'(o_main), 32'(O_NORM));
         check("idle_stall", stall_cycles, 32'd0);
         tick();
      end

      // 2. Load-use on rs.
      ex_memread = 1'b1; ex_rd = 5'd8; id_rs = 5'd8;
      #1;
      check("lu_rs_outs", 32'(o_main), 32'(O_LU));
      tick();
      clear_inputs();
      #1;
      check("lu_rs_after_outs", 32'(o_main), 32'(O_NORM));
      check("lu_rs_stall", stall_cycles, 32'd1);
      // Load to $0 is not a hazard.
      ex_memread = 1'b1; ex_rd = 5'd0; id_rs = 5'd0;
      #1;
      check("lu_r0_outs", 32'(o_main), 32'(O_NORM));
      tick();
      check("lu_r0_stall", stall_cycles, 32'd1);
      // rt match without id_uses_rt is not a hazard; with it, it is.
      ex_memread = 1'b1; ex_rd = 5'd8; id_rs = 5'd3; id_rt = 5'd8; id_uses_rt = 1'b0;
      #1;
      check("lu_rt_unused_outs", 32'(o_main), 32'(O_NORM));
      id_uses_rt = 1'b1;
      #1;
      check("lu_rt_used_outs", 32'(o_main), 32'(O_LU));
      tick();
      clear_inputs();
      #1;
      check("lu_rt_stall", stall_cycles, 32'd2);

      // 3. Taken branch wins over a load-use match.
      ex_memread = 1'b1; ex_rd = 5'd8; id_rs = 5'd8; ex_branch_tkn = 1'b1;
      #1;
      check("br_lu_outs", 32'(o_main), 32'(O_BR));
      tick();
      clear_inputs();
      #1;
      check("br_lu_stall", stall_cycles, 32'd2);

      // 4. Mul/div at T; branch at T+1 is ignored.
      ex_mdu_start = 1'b1;
      #1;
      check("mdu_t0", 32'(o_main), 32'(O_FRZ));
      tick();
      ex_mdu_start = 1'b0; ex_branch_tkn = 1'b1;
      #1;
      check("mdu_t1_br_ignored", 32'(o_main), 32'(O_FRZ));
      tick();
      ex_branch_tkn = 1'b0;
      #1;
      check("mdu_t2", 32'(o_main), 32'(O_FRZ));
      tick();
      check("mdu_t3_done", 32'(o_main), 32'(O_DONE));
      check("mdu_stall", stall_cycles, 32'd5);
      tick();
      check("mdu_t4_run", 32'(o_main), 32'(O_NORM));
      check("mdu_t4_stall", stall_cycles, 32'd5);

      // 5. Back-to-back mul/div: second start in the done cycle.
      ex_mdu_start = 1'b1;
      #1;
      check("b2b_t0", 32'(o_main), 32'(O_FRZ));
      tick();
      ex_mdu_start = 1'b0;
      #1;
      check("b2b_t1", 32'(o_main), 32'(O_FRZ));
      tick();
      check("b2b_t2", 32'(o_main), 32'(O_FRZ));
      tick();
      ex_mdu_start = 1'b1;
      #1;
      check("b2b_t3_done_frz", 32'(o_main), 32'(O_DFRZ));
      tick();
      ex_mdu_start = 1'b0;
      #1;
      check("b2b_t4", 32'(o_main), 32'(O_FRZ));
      tick();
      check("b2b_t5", 32'(o_main), 32'(O_FRZ));
      tick();
      check("b2b_t6_done", 32'(o_main), 32'(O_DONE));
      tick();
      check("b2b_t7_run", 32'(o_main), 32'(O_NORM));
      check("b2b_stall", stall_cycles, 32'd11);

      // 6. Reset during a freeze.
      ex_mdu_start = 1'b1;
      #1;
      tick();
      ex_mdu_start = 1'b0;
      #1;
      check("rst_mid_t1", 32'(o_main), 32'(O_FRZ));
      reset_b = 1'b0;
      #1;
      check("rst_mid_outs", 32'(o_main), 32'(O_ZERO));
      check("rst_mid_stall", stall_cycles, 32'd0);
      tick();
      reset_b = 1'b1;
      #1;
      check("rst_rel_outs", 32'(o_main), 32'(O_NORM));
      tick();
      check("rst_rel_no_done", 32'(o_main), 32'(O_NORM));
      check("rst_rel_stall", stall_cycles, 32'd0);

      // MDU_CYCLES=2: no freeze, done the next cycle.
      ex_mdu_start = 1'b1;
      #1;
      check("m2_start", 32'(o_m2), 32'(O_NORM));
      tick();
      ex_mdu_start = 1'b0;
      #1;
      check("m2_done", 32'(o_m2), 32'(O_DONE));
      tick();
      check("m2_run", 32'(o_m2), 32'(O_NORM));
      check("m2_stall", m2_stall_cycles, 32'd0);

      // CNT_W=3 counter saturates during a 15-cycle freeze.
      reset_b_s = 1'b1;
      ex_mdu_start = 1'b1;
      #1;
      check("sat_start", 32'(o_sat), 32'(O_FRZ));
      tick();
      ex_mdu_start = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      check("sat_count6", 32'(s_stall_cycles), 32'd6);
      for (int i = 0; i < 9; i++) tick();
      check("sat_done", 32'(o_sat), 32'(O_DONE));
      check("sat_count7", 32'(s_stall_cycles), 32'd7);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
